// File: rtl/debug_frame_uart_tx.sv
// ============================================================================
// Module   : debug_frame_uart_tx
// Purpose  : Sends one 10-byte debug frame (sync, cmd, addr, data, checksum)
//            per valid/ready request as UART 8N1 on TXD.
// Revision : 1.0
// ============================================================================
`default_nettype none

module debug_frame_uart_tx #(
  parameter int unsigned BAUD_PERIOD = 868
) (
  input  logic        clk,
  input  logic        sync_reset,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [7:0]  frame_cmd,
  input  logic [15:0] frame_addr,
  input  logic [31:0] frame_data,
  output logic        TXD,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [1:0]  c_ST_IDLE   = 2'd0;
  localparam logic [1:0]  c_ST_START  = 2'd1;
  localparam logic [1:0]  c_ST_DATA   = 2'd2;
  localparam logic [1:0]  c_ST_STOP   = 2'd3;

  localparam logic [15:0] c_BAUD_LOAD = 16'(BAUD_PERIOD - 1);
  localparam logic [3:0]  c_LAST_BYTE = 4'd9;
  localparam logic [2:0]  c_LAST_BIT  = 3'd7;
  localparam logic [7:0]  c_SYNC0     = 8'h5A;
  localparam logic [7:0]  c_SYNC1     = 8'hA5;

  logic [1:0]  state_q,    state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q,  bit_idx_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [79:0] buf_q,      buf_d;
  logic        txd_q,      txd_d;
  logic        busy_q,     busy_d;
  logic        done_q,     done_d;

  logic        w_accept;
  logic        w_baud_end;
  logic [7:0]  w_sum;
  logic [7:0]  w_checksum;
  logic [79:0] w_frame;
  logic [7:0]  w_cur_byte;

  assign frame_ready = (state_q == c_ST_IDLE) && !sync_reset;
  assign w_accept    = frame_valid && frame_ready;
  assign w_baud_end  = (baud_cnt_q == 16'd0);

  // Checksum makes the mod-256 sum of bytes 2..9 come out to zero.
  assign w_sum = frame_cmd
               + frame_addr[15:8] + frame_addr[7:0]
               + frame_data[31:24] + frame_data[23:16]
               + frame_data[15:8]  + frame_data[7:0];
  assign w_checksum = ~w_sum + 8'd1;

  // Byte 0 sits in bits [7:0] so byte_idx addresses the buffer directly.
  assign w_frame = {w_checksum,
                    frame_data[7:0], frame_data[15:8],
                    frame_data[23:16], frame_data[31:24],
                    frame_addr[7:0], frame_addr[15:8],
                    frame_cmd, c_SYNC1, c_SYNC0};

  assign w_cur_byte = buf_q[{byte_idx_q, 3'b000} +: 8];

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    buf_d      = buf_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      c_ST_IDLE: begin
        txd_d = 1'b1;
        if (w_accept) begin
          state_d    = c_ST_START;
          buf_d      = w_frame;
          byte_idx_d = 4'd0;
          bit_idx_d  = 3'd0;
          baud_cnt_d = c_BAUD_LOAD;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
        end
      end

      c_ST_START: begin
        if (w_baud_end) begin
          state_d    = c_ST_DATA;
          bit_idx_d  = 3'd0;
          baud_cnt_d = c_BAUD_LOAD;
          txd_d      = w_cur_byte[0];
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end

      c_ST_DATA: begin
        if (w_baud_end) begin
          baud_cnt_d = c_BAUD_LOAD;
          if (bit_idx_q == c_LAST_BIT) begin
            state_d = c_ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = w_cur_byte[bit_idx_q + 3'd1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end

      c_ST_STOP: begin
        if (w_baud_end) begin
          if (byte_idx_q == c_LAST_BYTE) begin
            state_d = c_ST_IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = c_ST_START;
            byte_idx_d = byte_idx_q + 4'd1;
            baud_cnt_d = c_BAUD_LOAD;
            txd_d      = 1'b0;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end

      default: begin
        state_d = c_ST_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q    <= c_ST_IDLE;
      baud_cnt_q <= 16'd0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 4'd0;
      buf_q      <= 80'd0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      buf_q      <= buf_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign TXD        = txd_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_debug_frame_uart_tx.sv
// ============================================================================
// Module   : tb_debug_frame_uart_tx
// Purpose  : Randomized bench for debug_frame_uart_tx with a UART line decoder
//            and a frame-level expected-byte queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_debug_frame_uart_tx;

  localparam int BP = 4;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic        frame_valid;
  logic        frame_ready;
  logic [7:0]  frame_cmd;
  logic [15:0] frame_addr;
  logic [31:0] frame_data;
  logic        TXD;
  logic        busy;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] exp_q [$];
  logic [7:0] last_frame [10];
  int  bif        = 0;
  int  fall_cyc   = 0;
  int  done_cyc   = 0;
  int  done_count = 0;
  bit  b2b_mode   = 1'b0;

  debug_frame_uart_tx #(.BAUD_PERIOD(BP)) u_dut (
    .clk         (clk),
    .sync_reset  (sync_reset),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_cmd   (frame_cmd),
    .frame_addr  (frame_addr),
    .frame_data  (frame_data),
    .TXD         (TXD),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: the ten wire bytes of a frame, from plain integer arithmetic.
  task automatic push_expected(input int c, input int a, input int d);
    int b [10];
    int s;
    b[0] = 'h5A;
    b[1] = 'hA5;
    b[2] = c;
    b[3] = a / 256;
    b[4] = a % 256;
    b[5] = (d >> 24) & 255;
    b[6] = (d >> 16) & 255;
    b[7] = (d >> 8) & 255;
    b[8] = d & 255;
    s = 0;
    for (int i = 2; i <= 8; i++) s += b[i];
    b[9] = (256 - (s % 256)) % 256;
    for (int i = 0; i < 10; i++) exp_q.push_back(8'(b[i]));
  endtask

  // Line decoder: samples TXD mid-bit on negedges and checks each byte.
  initial begin
    bit         act;
    int         p;
    logic [7:0] sh;
    logic [7:0] e;
    act = 1'b0;
    p   = 0;
    sh  = 8'd0;
    forever begin
      @(negedge clk);
      if (sync_reset === 1'b1) begin
        act = 1'b0;
        bif = 0;
        exp_q.delete();
      end else begin
        if (frame_done === 1'b1) begin
          chk("done_len", cyc - fall_cyc, 100 * BP);
          chk("done_busy", busy, 0);
          chk("done_bytes", bif, 0);
          done_cyc = cyc;
          done_count++;
        end
        if (!act && TXD === 1'b0) begin
          act = 1'b1;
          p   = 0;
          if (bif == 0) begin
            fall_cyc = cyc;
            if (b2b_mode) chk("b2b_gap", cyc - done_cyc, 1);
          end
        end
        if (act) begin
          if (p == BP / 2) chk("start_bit", TXD, 0);
          for (int k = 0; k < 8; k++)
            if (p == (k + 1) * BP + BP / 2) sh[k] = TXD;
          if (p == 9 * BP + BP / 2) begin
            chk("stop_bit", TXD, 1);
            if (exp_q.size() == 0) begin
              chk("unexpected_byte", exp_q.size(), 1);
            end else begin
              e = exp_q.pop_front();
              chk("rx_byte", sh, e);
            end
            last_frame[bif] = sh;
            bif = (bif + 1) % 10;
            act = 1'b0;
          end
          p++;
        end
      end
    end
  end

  task automatic send(input logic [7:0] c, input logic [15:0] a, input logic [31:0] d,
                      input bit hold);
    int n;
    frame_cmd   = c;
    frame_addr  = a;
    frame_data  = d;
    frame_valid = 1'b1;
    n = 0;
    while (frame_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      chk("accept_timeout", frame_ready, 1);
      frame_valid = 1'b0;
    end else begin
      push_expected(int'(c), int'(a), int'(d));
      @(negedge clk);
      if (!hold) frame_valid = 1'b0;
      chk("accept_busy", busy, 1);
      chk("accept_txd", TXD, 0);
    end
  endtask

  task automatic wait_done();
    int n;
    int dc0;
    dc0 = done_count;
    n = 0;
    while (done_count == dc0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(done_count != dc0), 1);
  endtask

  initial begin
    #(50000 * 10);
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lit [10];
    int s;
    int dc;
    bit saw_low;
    bit hold;

    lit = '{8'h5A, 8'hA5, 8'h01, 8'h00, 8'h10, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDB};
    sync_reset  = 1'b1;
    frame_valid = 1'b0;
    frame_cmd   = 8'd0;
    frame_addr  = 16'd0;
    frame_data  = 32'd0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", frame_ready, 0);
    end
    chk("rst_txd", TXD, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    sync_reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", frame_ready, 1);
    chk("post_rst_txd", TXD, 1);

    send(8'h01, 16'h0010, 32'h12345678, 1'b0);
    wait_done();
    for (int i = 0; i < 10; i++) chk("single_lit", last_frame[i], lit[i]);

    send(8'hFF, 16'hFFFF, 32'hFFFFFFFF, 1'b0);
    wait_done();
    chk("wrap_ck", last_frame[9], 8'h07);
    s = 0;
    for (int i = 2; i < 10; i++) s += int'(last_frame[i]);
    chk("wrap_sum", s % 256, 0);

    send(8'h3C, 16'hBEEF, 32'hCAFEF00D, 1'b1);
    b2b_mode = 1'b1;
    send(8'hC3, 16'h1234, 32'h0BADF00D, 1'b0);
    @(negedge clk);
    b2b_mode = 1'b0;
    wait_done();

    send(8'h22, 16'h4455, 32'h66778899, 1'b0);
    repeat (60) @(negedge clk);
    frame_cmd   = 8'(~8'h22);
    frame_addr  = 16'hA5A5;
    frame_data  = 32'hDEADBEEF;
    frame_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("busy_ready", frame_ready, 0);
    end
    frame_valid = 1'b0;
    wait_done();
    saw_low = 1'b0;
    repeat (3 * BP) begin
      @(negedge clk);
      if (TXD !== 1'b1) saw_low = 1'b1;
    end
    chk("no_second_frame", saw_low, 0);
    chk("idle_busy", busy, 0);

    send(8'($urandom), 16'($urandom), $urandom, 1'b0);
    repeat (4 * 10 * BP + 4 * BP + 1) @(negedge clk);
    dc = done_count;
    sync_reset = 1'b1;
    @(negedge clk);
    chk("abort_txd", TXD, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", frame_done, 0);
    chk("abort_ready", frame_ready, 0);
    @(negedge clk);
    sync_reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", frame_ready, 1);
    send(8'h5A, 16'hA55A, 32'h01020304, 1'b0);
    wait_done();
    chk("abort_done_count", done_count, dc + 1);

    for (int i = 0; i < 8; i++) begin
      hold = ($urandom_range(0, 3) == 0) && (i != 7);
      send(8'($urandom), 16'($urandom), $urandom, hold);
      if (!hold) begin
        wait_done();
        repeat ($urandom_range(1, 15)) @(negedge clk);
      end
    end
    repeat (4) @(negedge clk);
    chk("final_idle_busy", busy, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
